// File: rtl/rr_stream_mux_if.sv
// rtl/rr_stream_mux_if.sv - stream mux bus: packed per-channel input streams and one registered output stream
interface rr_stream_mux_if #(
   parameter int N        = 1,
   parameter int CHANNELS = 8
);
   localparam int CW = $clog2(CHANNELS);

   logic [CHANNELS*N-1:0] in_data;
   logic [CHANNELS-1:0]   in_valid;
   logic [CHANNELS-1:0]   in_ready;
   logic [N-1:0]          out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [CW-1:0]         out_channel;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_channel
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_channel
   );
endinterface

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - CHANNELS-way round-robin stream mux with optional burst lock and registered output
module rr_stream_mux #(
   parameter int N        = 1,
   parameter int CHANNELS = 8,
   parameter int LOCK_LEN = 1,
   localparam int CW      = $clog2(CHANNELS)
) (
   input logic            clk,
   input logic            rst,
   rr_stream_mux_if.slave bus
);
   localparam int CNTW = $clog2(LOCK_LEN + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   last_q, last_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [N-1:0]    data_q;
   logic            valid_q;
   logic [CW-1:0]   chan_q;

   logic [CW-1:0]       grant;
   logic                grant_found;
   logic [CW-1:0]       scan_base;
   logic [CW:0]         scan_idx;
   logic                load;
   logic                xfer;
   logic [CHANNELS-1:0] ready_c;

   assign load = !valid_q || bus.out_ready;
   assign xfer = grant_found && load;

   // A lapsed lock scans from its owner, so the released channel goes to the back of the queue.
   always_comb begin
      grant_found = 1'b0;
      grant       = '0;
      scan_base   = '0;
      scan_idx    = '0;
      if (state_q == LOCKED && bus.in_valid[owner_q]) begin
         grant_found = 1'b1;
         grant       = owner_q;
      end else begin
         scan_base = (state_q == LOCKED) ? owner_q : last_q;
         // Walk the scan order backwards so the nearest valid channel is the last one written.
         for (int k = CHANNELS; k >= 1; k--) begin
            scan_idx = {1'b0, scan_base} + (CW+1)'(k);
            if (scan_idx >= (CW+1)'(CHANNELS))
               scan_idx = scan_idx - (CW+1)'(CHANNELS);
            if (bus.in_valid[scan_idx[CW-1:0]]) begin
               grant_found = 1'b1;
               grant       = scan_idx[CW-1:0];
            end
         end
      end
   end

   always_comb begin
      ready_c = '0;
      if (xfer && !rst)
         ready_c[grant] = 1'b1;
   end

   assign bus.in_ready = ready_c;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               if (LOCK_LEN == 1) begin
                  last_d = grant;
               end else begin
                  state_d = LOCKED;
                  owner_d = grant;
                  count_d = CNTW'(1);
               end
            end
         end
         LOCKED: begin
            if (load) begin
               if (bus.in_valid[owner_q]) begin
                  if (int'(count_q) + 1 == LOCK_LEN) begin
                     state_d = IDLE;
                     last_d  = owner_q;
                     count_d = '0;
                  end else begin
                     count_d = count_q + CNTW'(1);
                  end
               end else begin
                  // Owner went idle: release, and any same-cycle pick starts a fresh grant.
                  state_d = IDLE;
                  last_d  = owner_q;
                  count_d = '0;
                  if (xfer) begin
                     if (LOCK_LEN == 1) begin
                        last_d = grant;
                     end else begin
                        state_d = LOCKED;
                        owner_d = grant;
                        count_d = CNTW'(1);
                     end
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= CW'(CHANNELS - 1);
         count_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
      end else if (load) begin
         valid_q <= xfer;
         if (xfer) begin
            data_q <= bus.in_data[int'(grant) * N +: N];
            chan_q <= grant;
         end
      end
   end

   assign bus.out_data    = data_q;
   assign bus.out_valid   = valid_q;
   assign bus.out_channel = chan_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - vector tables, corner sequences and a reference model over four mux configurations
module tb_rr_stream_mux;
   function automatic int ch_of(int g);
      return (g == 2) ? 5 : 8;
   endfunction

   function automatic int lk_of(int g);
      return (g == 1) ? 3 : ((g == 3) ? 4 : 1);
   endfunction

   logic                 clk = 1'b0;
   logic [3:0]           rst;
   logic [3:0][31:0]     vld;
   logic [3:0]           ordy;
   logic [3:0][31:0][3:0] dat;
   logic [3:0][31:0]     irdy;
   logic [3:0][3:0]      od;
   logic [3:0]           ov;
   logic [3:0][4:0]      och;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : cfg
      localparam int CH = ch_of(g);
      localparam int LK = lk_of(g);
      rr_stream_mux_if #(.N(4), .CHANNELS(CH)) bus ();
      rr_stream_mux #(.N(4), .CHANNELS(CH), .LOCK_LEN(LK)) dut (
         .clk (clk),
         .rst (rst[g]),
         .bus (bus)
      );
      assign bus.in_data   = dat[g][CH-1:0];
      assign bus.in_valid  = vld[g][CH-1:0];
      assign bus.out_ready = ordy[g];
      assign irdy[g]       = 32'(bus.in_ready);
      assign od[g]         = bus.out_data;
      assign ov[g]         = bus.out_valid;
      assign och[g]        = 5'(bus.out_channel);
   end

   int checks = 0;
   int errors = 0;

   // Reference model: priority pointer, current lock owner and beats left in the lock.
   int m_prio [4], m_owner [4], m_left [4], m_od [4], m_och [4];
   bit m_ov [4];
   int n_prio [4], n_owner [4], n_left [4], n_od [4], n_och [4];
   bit n_ov [4];

   task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cfg%0d actual=%0h required=%0h t=%0t", nm, g, act, exp, $time);
      end
   endtask

   function automatic void model_reset(int g);
      m_prio[g]  = 0;
      m_owner[g] = -1;
      m_left[g]  = 0;
      m_od[g]    = 0;
      m_och[g]   = 0;
      m_ov[g]    = 1'b0;
   endfunction

   function automatic int pick(int g);
      int start;
      int c;
      if (m_owner[g] >= 0 && vld[g][m_owner[g]]) return m_owner[g];
      start = (m_owner[g] >= 0) ? m_owner[g] + 1 : m_prio[g];
      for (int k = 0; k < ch_of(g); k++) begin
         c = (start + k) % ch_of(g);
         if (vld[g][c]) return c;
      end
      return -1;
   endfunction

   task automatic model_check();
      for (int g = 0; g < 4; g++) begin
         int gs;
         int ch;
         bit load;
         logic [31:0] er;
         ch = ch_of(g);
         n_prio[g] = m_prio[g]; n_owner[g] = m_owner[g]; n_left[g] = m_left[g];
         n_od[g] = m_od[g]; n_och[g] = m_och[g]; n_ov[g] = m_ov[g];
         er = '0;
         chk("out_valid", g, 32'(ov[g]), 32'(m_ov[g]));
         chk("out_data", g, 32'(od[g]), m_od[g]);
         chk("out_channel", g, 32'(och[g]), m_och[g]);
         if (!rst[g]) begin
            load = !m_ov[g] || ordy[g];
            gs = pick(g);
            if (gs >= 0 && load) er = 32'd1 << gs;
            if (load) begin
               if (gs < 0) begin
                  n_ov[g] = 1'b0;
                  if (m_owner[g] >= 0) begin
                     n_prio[g]  = (m_owner[g] + 1) % ch;
                     n_owner[g] = -1;
                  end
               end else begin
                  n_ov[g]  = 1'b1;
                  n_od[g]  = 32'(dat[g][gs]);
                  n_och[g] = gs;
                  if (gs == m_owner[g]) begin
                     n_left[g] = m_left[g] - 1;
                     if (n_left[g] == 0) begin
                        n_prio[g]  = (gs + 1) % ch;
                        n_owner[g] = -1;
                     end
                  end else if (lk_of(g) == 1) begin
                     n_prio[g]  = (gs + 1) % ch;
                     n_owner[g] = -1;
                  end else begin
                     n_owner[g] = gs;
                     n_left[g]  = lk_of(g) - 1;
                  end
               end
            end
         end
         chk("in_ready", g, irdy[g], er);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
         m_prio[g] = n_prio[g]; m_owner[g] = n_owner[g]; m_left[g] = n_left[g];
         m_od[g] = n_od[g]; m_och[g] = n_och[g]; m_ov[g] = n_ov[g];
      end
   endtask

   typedef struct {
      int          g;
      logic [31:0] v;
      bit          r;
      logic [31:0] ei;
      bit          eov;
      int          eoch;
      int          eod;
   } vec_t;

   vec_t rows[$];

   function automatic void add(int g, logic [31:0] v, bit r, logic [31:0] ei, bit eov, int eoch, int eod);
      vec_t x;
      x.g = g; x.v = v; x.r = r; x.ei = ei; x.eov = eov; x.eoch = eoch; x.eod = eod;
      rows.push_back(x);
   endfunction

   function automatic int dv(int g, int c);
      return (g == 1 && c == 3) ? 10 : c;
   endfunction

   function automatic void run(int g, logic [31:0] v, int c, int n);
      for (int i = 0; i < n; i++) add(g, v, 1'b1, 32'd1 << c, 1'b1, c, dv(g, c));
   endfunction

   initial begin
      rst  = '1;
      vld  = '0;
      ordy = '1;
      for (int g = 0; g < 4; g++) begin
         for (int i = 0; i < 32; i++) dat[g][i] = 4'(i);
         model_reset(g);
      end
      dat[1][3] = 4'hA;

      for (int i = 0; i < 9; i++) run(0, 32'hFF, i % 8, 1);
      for (int i = 0; i < 4; i++) run(0, 32'h24, (i % 2) ? 5 : 2, 1);
      run(0, 32'h04, 2, 3);

      run(1, 32'hFF, 0, 3);
      run(1, 32'hFF, 1, 1);
      run(1, 32'hFD, 2, 3);
      run(1, 32'hFD, 3, 1);
      for (int i = 0; i < 4; i++) add(1, 32'hFD, 1'b0, 32'h0, 1'b1, 3, 10);
      run(1, 32'hFD, 3, 2);
      for (int c = 4; c < 8; c++) run(1, 32'hFD, c, 3);
      run(1, 32'hFF, 0, 3);
      run(1, 32'hFF, 1, 1);

      run(2, 32'h10, 4, 1);
      for (int i = 0; i < 4; i++) run(2, 32'h11, (i % 2) ? 4 : 0, 1);
      for (int i = 0; i < 6; i++) run(2, 32'h1F, i % 5, 1);

      #1;
      tick();
      tick();
      rst = '0;

      foreach (rows[i]) begin
         vld[rows[i].g]  = rows[i].v;
         ordy[rows[i].g] = rows[i].r;
         #2;
         chk("tbl_in_ready", rows[i].g, irdy[rows[i].g], rows[i].ei);
         tick();
         chk("tbl_out_valid", rows[i].g, 32'(ov[rows[i].g]), 32'(rows[i].eov));
         chk("tbl_out_channel", rows[i].g, 32'(och[rows[i].g]), rows[i].eoch);
         chk("tbl_out_data", rows[i].g, 32'(od[rows[i].g]), rows[i].eod);
      end

      vld[3] = 32'h40;
      tick();
      tick();
      chk("lock_out_channel", 3, 32'(och[3]), 6);
      chk("lock_out_valid", 3, 32'(ov[3]), 1);
      #2;
      rst[3] = 1'b1;
      model_reset(3);
      #1;
      chk("arst_out_valid", 3, 32'(ov[3]), 0);
      chk("arst_out_data", 3, 32'(od[3]), 0);
      chk("arst_out_channel", 3, 32'(och[3]), 0);
      chk("arst_in_ready", 3, irdy[3], 0);
      vld[3] = 32'hFF;
      tick();
      rst[3] = 1'b0;
      #2;
      chk("post_rst_in_ready", 3, irdy[3], 32'h1);
      tick();
      chk("post_rst_channel", 3, 32'(och[3]), 0);
      chk("post_rst_valid", 3, 32'(ov[3]), 1);
      repeat (3) tick();
      chk("lock4_last_beat", 3, 32'(och[3]), 0);
      tick();
      chk("lock4_next_owner", 3, 32'(och[3]), 1);

      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int g = 0; g < 4; g++) begin
            if (rst[g]) begin
               rst[g] = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
               rst[g] = 1'b1;
               model_reset(g);
            end
            case ((cyc / 64) % 3)
               0:       vld[g] = $urandom() & $urandom();
               1:       vld[g] = $urandom();
               default: vld[g] = $urandom() | $urandom();
            endcase
            ordy[g] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 32; i++) dat[g][i] = 4'($urandom());
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
